// File: rtl/icache_pkg.sv
// Shared ICache definitions: line geometry, AXI read encodings and the
// refill FSM state encoding (also used by the ICache main FSM).
package icache_pkg;

  localparam int ICACHE_BEATS  = 8;
  localparam int ICACHE_BEAT_W = 32;
  localparam int ICACHE_LINE_W = ICACHE_BEATS * ICACHE_BEAT_W;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    REFILL_IDLE  = 3'd0,
    REFILL_AR    = 3'd1,
    REFILL_R     = 3'd2,
    REFILL_DONE  = 3'd3,
    REFILL_DRAIN = 3'd4
  } refill_state_e;

  // Any response other than OKAY marks the beat as erroneous.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/icache_refill_linebuf.sv
// Line assembly buffer: LINEBEATS words of BEATWIDE bits, one indexed write
// per cycle, whole line presented flat (word i at bits [BEATWIDE*i +: BEATWIDE]).
// rst_n is a synchronous active-low clear.
module icache_refill_linebuf #(
  parameter int BEATWIDE  = 32,
  parameter int LINEBEATS = 8,
  parameter int IDXW      = $clog2(LINEBEATS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [IDXW-1:0]               widx,
  input  logic [BEATWIDE-1:0]           wdata,
  output logic [BEATWIDE*LINEBEATS-1:0] line
);

  logic [BEATWIDE-1:0] mem_r [LINEBEATS];

  // Word storage: cleared on reset, one indexed write per beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LINEBEATS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[widx] <= wdata;
    end
  end

  // Flatten the words into the line bus.
  always_comb begin
    line = '0;
    for (int i = 0; i < LINEBEATS; i++) begin
      line[i*BEATWIDE +: BEATWIDE] = mem_r[i];
    end
  end

endmodule

// File: rtl/icache_refill_unit.sv
// ICache miss-refill engine: one miss -> one AXI read (8-beat line or single
// uncached beat), beats assembled into a line returned with a 1-cycle pulse.
// A flush drains the outstanding burst without returning data.
// Optional build macro ICACHE_REFILL_CWF_EN: critical-word-first (WRAP burst
// starting at the missed word, CritValid/CritWord ports).
module icache_refill_unit
  import icache_pkg::*;
#(
  parameter int ADDRWIDE  = 32,
  parameter int BEATWIDE  = ICACHE_BEAT_W,
  parameter int LINEBEATS = ICACHE_BEATS
) (
  input  logic                          Clk,
  input  logic                          Rest,
  input  logic                          MissReq,
  input  logic [ADDRWIDE-1:0]           MissAddr,
  input  logic                          MissCached,
  input  logic                          Flush,
  output logic                          RefillBusy,
  output logic                          ArValid,
  input  logic                          ArReady,
  output logic [ADDRWIDE-1:0]           ArAddr,
  output logic [7:0]                    ArLen,
  output logic [2:0]                    ArSize,
  output logic [1:0]                    ArBurst,
  input  logic                          RValid,
  output logic                          RReady,
  input  logic [BEATWIDE-1:0]           RData,
  input  logic [1:0]                    RResp,
  input  logic                          RLast,
  output logic                          LineValid,
  output logic [BEATWIDE*LINEBEATS-1:0] LineData,
  output logic [ADDRWIDE-1:0]           LineAddr,
  output logic                          LineCached,
`ifdef ICACHE_REFILL_CWF_EN
  output logic                          CritValid,
  output logic [BEATWIDE-1:0]           CritWord,
`endif
  output logic                          LineErr
);

  localparam int IDXW = $clog2(LINEBEATS);
  localparam int OFFW = $clog2(BEATWIDE / 8);
  localparam logic [ADDRWIDE-1:0] BEAT_MASK = ~(ADDRWIDE'(BEATWIDE / 8 - 1));
  localparam logic [ADDRWIDE-1:0] LINE_MASK = ~(ADDRWIDE'(BEATWIDE / 8 * LINEBEATS - 1));

  refill_state_e       state_r, next_state_s;
  logic                accept_s, beat_s;
  logic                busy_r, arvalid_r, rready_r, pend_r, first_r, err_r, cached_r;
  logic [IDXW-1:0]     idx_r, start_idx_s;
  logic [ADDRWIDE-1:0] araddr_r, araddr_s, lineaddr_r;
  logic [7:0]          arlen_r, arlen_s;
  logic [1:0]          arburst_s;
`ifdef ICACHE_REFILL_CWF_EN
  logic [1:0]          arburst_r;
`endif

  // Next state plus the accept / beat-capture strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    beat_s       = 1'b0;
    case (state_r)
      REFILL_IDLE: begin
        if (MissReq && !Flush) begin
          accept_s     = 1'b1;
          next_state_s = REFILL_AR;
        end else begin
          next_state_s = REFILL_IDLE;
        end
      end
      REFILL_AR: begin
        if (ArReady) begin
          next_state_s = (pend_r || Flush) ? REFILL_DRAIN : REFILL_R;
        end else begin
          next_state_s = REFILL_AR;
        end
      end
      REFILL_R: begin
        beat_s = RValid && !Flush;
        if (Flush) begin
          // A flush on the last beat itself has nothing left to drain.
          next_state_s = (RValid && RLast) ? REFILL_IDLE : REFILL_DRAIN;
        end else if (RValid && RLast) begin
          next_state_s = REFILL_DONE;
        end else begin
          next_state_s = REFILL_R;
        end
      end
      REFILL_DONE: begin
        next_state_s = REFILL_IDLE;
      end
      REFILL_DRAIN: begin
        next_state_s = (RValid && RLast) ? REFILL_IDLE : REFILL_DRAIN;
      end
      default: begin
        next_state_s = REFILL_IDLE;
      end
    endcase
  end

  // AR request fields and first write index derived from the incoming miss.
  always_comb begin
    start_idx_s = MissAddr[OFFW +: IDXW];
    arburst_s   = AXI_BURST_INCR;
    if (MissCached) begin
      arlen_s = 8'(LINEBEATS - 1);
`ifdef ICACHE_REFILL_CWF_EN
      araddr_s  = MissAddr & BEAT_MASK;
      arburst_s = AXI_BURST_WRAP;
`else
      araddr_s    = MissAddr & LINE_MASK;
      start_idx_s = '0;
`endif
    end else begin
      arlen_s  = 8'd0;
      araddr_s = MissAddr & BEAT_MASK;
    end
  end

  // FSM state, registered AXI controls and per-miss capture registers.
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      state_r    <= REFILL_IDLE;
      busy_r     <= 1'b0;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
      pend_r     <= 1'b0;
      first_r    <= 1'b0;
      err_r      <= 1'b0;
      cached_r   <= 1'b0;
      idx_r      <= '0;
      araddr_r   <= '0;
      arlen_r    <= 8'd0;
      lineaddr_r <= '0;
`ifdef ICACHE_REFILL_CWF_EN
      arburst_r  <= AXI_BURST_INCR;
`endif
    end else begin
      state_r   <= next_state_s;
      busy_r    <= (next_state_s != REFILL_IDLE);
      arvalid_r <= (next_state_s == REFILL_AR);
      rready_r  <= (next_state_s == REFILL_R) || (next_state_s == REFILL_DRAIN);
      // Flush seen while AR is outstanding is remembered until the handshake.
      pend_r    <= (next_state_s == REFILL_AR) && (pend_r || ((state_r == REFILL_AR) && Flush));
      if (accept_s) begin
        cached_r   <= MissCached;
        araddr_r   <= araddr_s;
        arlen_r    <= arlen_s;
        lineaddr_r <= MissAddr & LINE_MASK;
        idx_r      <= start_idx_s;
        err_r      <= 1'b0;
        first_r    <= 1'b1;
`ifdef ICACHE_REFILL_CWF_EN
        arburst_r  <= arburst_s;
`endif
      end else if (beat_s) begin
        idx_r   <= idx_r + IDXW'(1);
        err_r   <= err_r | resp_is_err(RResp);
        first_r <= 1'b0;
      end
    end
  end

  icache_refill_linebuf #(
    .BEATWIDE  (BEATWIDE),
    .LINEBEATS (LINEBEATS)
  ) u_linebuf (
    .clk   (Clk),
    .rst_n (Rest),
    .we    (beat_s),
    .widx  (idx_r),
    .wdata (RData),
    .line  (LineData)
  );

  assign RefillBusy = busy_r;
  assign ArValid    = arvalid_r;
  assign ArAddr     = araddr_r;
  assign ArLen      = arlen_r;
  assign ArSize     = AXI_SIZE_4B;
  assign RReady     = rready_r;
  assign LineValid  = (state_r == REFILL_DONE) && !Flush;
  assign LineAddr   = lineaddr_r;
  assign LineCached = cached_r;
  assign LineErr    = err_r;
`ifdef ICACHE_REFILL_CWF_EN
  assign ArBurst    = arburst_r;
  assign CritValid  = (state_r == REFILL_R) && RValid && first_r;
  assign CritWord   = RData;
`else
  assign ArBurst    = AXI_BURST_INCR;
  logic unused_s;
  assign unused_s   = ^arburst_s;
`endif

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed, table-driven bench for icache_refill_unit plus hand-written
// sequences for flush drain, mid-burst reset and (when built with
// ICACHE_REFILL_CWF_EN) critical-word-first ordering.
module tb_icache_refill_unit;

`ifdef ICACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rest, MissReq, MissCached, Flush, ArReady, RValid, RLast;
  logic [31:0]  MissAddr, RData;
  logic [1:0]   RResp;
  logic         RefillBusy, ArValid, RReady, LineValid, LineCached, LineErr;
  logic [31:0]  ArAddr, LineAddr;
  logic [7:0]   ArLen;
  logic [2:0]   ArSize;
  logic [1:0]   ArBurst;
  logic [255:0] LineData;
`ifdef ICACHE_REFILL_CWF_EN
  logic         CritValid;
  logic [31:0]  CritWord;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 Clk = ~Clk;

  icache_refill_unit dut (
    .Clk(Clk), .Rest(Rest), .MissReq(MissReq), .MissAddr(MissAddr),
    .MissCached(MissCached), .Flush(Flush), .RefillBusy(RefillBusy),
    .ArValid(ArValid), .ArReady(ArReady), .ArAddr(ArAddr), .ArLen(ArLen),
    .ArSize(ArSize), .ArBurst(ArBurst), .RValid(RValid), .RReady(RReady),
    .RData(RData), .RResp(RResp), .RLast(RLast), .LineValid(LineValid),
    .LineData(LineData), .LineAddr(LineAddr), .LineCached(LineCached),
`ifdef ICACHE_REFILL_CWF_EN
    .CritValid(CritValid), .CritWord(CritWord),
`endif
    .LineErr(LineErr)
  );

  typedef struct {
    logic        cached;
    logic [31:0] addr;
    logic [31:0] data0;
    logic [31:0] step;
    int          err_beat;
    int          gap;
    int          arwait;
    logic [31:0] exp_araddr;
    logic [7:0]  exp_arlen;
    logic [1:0]  exp_burst;
    logic [31:0] exp_lineaddr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One complete miss with the bench's own model of word placement.
  task automatic run_vec(input vec_t v);
    int n;
    int start;
    logic [31:0] w;
    n     = v.cached ? 8 : 1;
    start = (v.cached && !CWF) ? 0 : int'(v.addr[4:2]);
    tick();
    MissReq = 1'b1; MissAddr = v.addr; MissCached = v.cached;
    tick();
    MissReq = 1'b0;
    chk("arvalid", ArValid, 1'b1);
    chk("araddr", ArAddr, v.exp_araddr);
    chk("arlen", ArLen, v.exp_arlen);
    chk("arburst", ArBurst, v.exp_burst);
    chk("busy", RefillBusy, 1'b1);
    for (int c = 0; c < v.arwait; c++) begin
      tick();
      chk("arvalid_hold", ArValid, 1'b1);
      chk("araddr_hold", ArAddr, v.exp_araddr);
    end
    ArReady = 1'b1;
    tick();
    ArReady = 1'b0;
    chk("rready", RReady, 1'b1);
    chk("arvalid_drop", ArValid, 1'b0);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < v.gap; g++) tick();
      RValid = 1'b1;
      RData  = v.data0 + v.step * 32'(k);
      RResp  = (k == v.err_beat) ? 2'b10 : 2'b00;
      RLast  = (k == n - 1);
      chk("linevalid_early", LineValid, 1'b0);
      tick();
      RValid = 1'b0; RLast = 1'b0; RResp = 2'b00;
    end
    chk("linevalid", LineValid, 1'b1);
    chk("lineerr", LineErr, v.exp_err);
    chk("lineaddr", LineAddr, v.exp_lineaddr);
    chk("linecached", LineCached, v.cached);
    for (int k = 0; k < n; k++) begin
      w = LineData[((start + k) % 8) * 32 +: 32];
      chk("lineword", w, v.data0 + v.step * 32'(k));
    end
    tick();
    chk("linevalid_pulse", LineValid, 1'b0);
    chk("busy_idle", RefillBusy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h1C00_0044, 32'h11, 32'h11, 8, 0, 0,
                CWF ? 32'h1C00_0044 : 32'h1C00_0040, 8'd7,
                CWF ? 2'b10 : 2'b01, 32'h1C00_0040, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_100C, 32'hDEAD_BEEF, 32'h0, 8, 0, 0,
                32'h0000_100C, 8'd0, 2'b01, 32'h0000_1000, 1'b0};
    vecs[2] = '{1'b1, 32'h2000_0000, 32'hA000_0001, 32'h1, 3, 2, 0,
                32'h2000_0000, 8'd7, CWF ? 2'b10 : 2'b01, 32'h2000_0000, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_003C, 32'h100, 32'h100, 8, 0, 3,
                CWF ? 32'h0000_003C : 32'h0000_0020, 8'd7,
                CWF ? 2'b10 : 2'b01, 32'h0000_0020, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h5A5A_0001, 32'h0, 8, 1, 1,
                32'hFFFF_FFFC, 8'd0, 2'b01, 32'hFFFF_FFE0, 1'b0};

    Rest = 1'b0; MissReq = 1'b0; MissAddr = 32'h0; MissCached = 1'b0;
    Flush = 1'b0; ArReady = 1'b0; RValid = 1'b0; RData = 32'h0;
    RResp = 2'b00; RLast = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rest = 1'b1;
    chk("rst_busy", RefillBusy, 1'b0);
    chk("rst_arvalid", ArValid, 1'b0);
    chk("rst_rready", RReady, 1'b0);
    chk("rst_linevalid", LineValid, 1'b0);
    chk("rst_linedata", LineData, 256'h0);
    chk("rst_arsize", ArSize, 3'b010);
    chk("rst_arburst", ArBurst, 2'b01);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Flush while AR waits: request held stable, burst drained, no line.
    tick();
    MissReq = 1'b1; MissAddr = 32'h3000_0080; MissCached = 1'b1;
    tick();
    MissReq = 1'b0;
    for (int c = 0; c < 5; c++) begin
      Flush = (c == 1);
      chk("fl_arvalid", ArValid, 1'b1);
      chk("fl_araddr", ArAddr, 32'h3000_0080);
      tick();
    end
    Flush = 1'b0;
    chk("fl_arvalid_wait", ArValid, 1'b1);
    ArReady = 1'b1;
    tick();
    ArReady = 1'b0;
    for (int k = 0; k < 8; k++) begin
      RValid = 1'b1; RData = 32'hF000_0000 + 32'(k); RLast = (k == 7);
      chk("fl_rready", RReady, 1'b1);
      chk("fl_busy", RefillBusy, 1'b1);
      chk("fl_linevalid", LineValid, 1'b0);
      tick();
    end
    RValid = 1'b0; RLast = 1'b0;
    chk("fl_busy_drop", RefillBusy, 1'b0);
    chk("fl_linevalid_end", LineValid, 1'b0);
    tick();
    chk("fl_linevalid_after", LineValid, 1'b0);

    // Reset after the third beat of a burst, then a normal miss.
    tick();
    MissReq = 1'b1; MissAddr = 32'h4000_0000; MissCached = 1'b1;
    tick();
    MissReq = 1'b0; ArReady = 1'b1;
    tick();
    ArReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      RValid = 1'b1; RData = 32'h7700_0000 + 32'(k); RResp = 2'b11;
      tick();
    end
    RValid = 1'b0; RResp = 2'b00;
    Rest = 1'b0;
    tick();
    Rest = 1'b1;
    chk("mr_busy", RefillBusy, 1'b0);
    chk("mr_arvalid", ArValid, 1'b0);
    chk("mr_araddr", ArAddr, 32'h0);
    chk("mr_arlen", ArLen, 8'd0);
    chk("mr_rready", RReady, 1'b0);
    chk("mr_linevalid", LineValid, 1'b0);
    chk("mr_linedata", LineData, 256'h0);
    chk("mr_lineaddr", LineAddr, 32'h0);
    chk("mr_linecached", LineCached, 1'b0);
    chk("mr_lineerr", LineErr, 1'b0);
    run_vec(vecs[0]);

`ifdef ICACHE_REFILL_CWF_EN
    // Critical word first: first beat is word6, order wraps to word5.
    tick();
    MissReq = 1'b1; MissAddr = 32'h1C00_0058; MissCached = 1'b1;
    tick();
    MissReq = 1'b0;
    chk("cwf_araddr", ArAddr, 32'h1C00_0058);
    chk("cwf_arburst", ArBurst, 2'b10);
    ArReady = 1'b1;
    tick();
    ArReady = 1'b0;
    for (int k = 0; k < 8; k++) begin
      RValid = 1'b1; RData = 32'hC0DE_0000 + 32'(k); RLast = (k == 7);
      #1;
      chk("cwf_critvalid", CritValid, (k == 0));
      if (k == 0) chk("cwf_critword", CritWord, 32'hC0DE_0000);
      tick();
    end
    RValid = 1'b0; RLast = 1'b0;
    chk("cwf_linevalid", LineValid, 1'b1);
    chk("cwf_word6", LineData[6*32 +: 32], 32'hC0DE_0000);
    chk("cwf_word7", LineData[7*32 +: 32], 32'hC0DE_0001);
    chk("cwf_word0", LineData[0 +: 32], 32'hC0DE_0002);
    chk("cwf_word5", LineData[5*32 +: 32], 32'hC0DE_0007);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
